mem_responder: RTL
==================

Name: mem_responder

Overview:
- Responder end of the cache-to-memory interface: the backing data memory that a cache controller drives during refills and write-throughs.
- Accepts one word-addressed read or write request per transaction through a valid/ready handshake.
- Models main-memory access time with a programmable latency counter.
- Returns read data, or a write acknowledge, as a single-cycle response pulse.
- Replaces the zero-latency data memory so that the controller's stall path is exercised over multiple cycles.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words.
- DATA_W, 32, data word width.
- LATENCY, 4, wait cycles between request acceptance and response; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_write  input  1  1 = write, 0 = read; sampled only at acceptance.
- req_addr  input  ADDR_W  word address; sampled only at acceptance.
- req_wdata  input  DATA_W  write data; sampled only at acceptance.
- req_ready  output  1  responder can accept a request (high only in IDLE).
- resp_valid  output  1  one-cycle pulse; the read data is valid, or the write has committed.
- resp_rdata  output  DATA_W  read data; holds its last value between responses.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset (RST low, asynchronous):
  - State goes to IDLE; req_ready=1, resp_valid=0, busy=0.
  - resp_rdata=0; latched address, data and write flag =0; latency counter=0.
  - Memory array contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP (2-bit encoding).
- IDLE:
  - A request is accepted on an edge where req_valid && req_ready.
  - At acceptance: latch addr, wdata and write; load cnt=LATENCY-1; go to WAIT.
- WAIT:
  - If cnt!=0: cnt decrements by 1 each edge.
  - If cnt==0: the access occurs at this edge, and the state goes to RESP.
    - Write: array[addr] <= wdata.
    - Read: resp_rdata <= array[addr].
- RESP:
  - resp_valid=1 for exactly this one cycle, independent of req_valid.
  - Next edge goes to IDLE unconditionally.
- Timing:
  - Request accepted at edge n → resp_valid high in the cycle after edge n+LATENCY.
  - req_ready high again after edge n+LATENCY+1.
  - Back-to-back throughput: one transaction per LATENCY+2 cycles.
- Requests presented while req_ready=0 are ignored; the initiator holds req_valid until accepted.
- Request inputs are don't-care outside the acceptance edge; changes during WAIT have no effect.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Write and read never occur at the same edge; there is a single array port.
- Reset during WAIT aborts the transaction: no array write, no resp_valid.
- Reset during RESP:
  - A write in flight has already committed.
  - The response pulse is cut short.
- Counter width: 4 bits; LATENCY outside 1..15 is a synthesis-time error.
- All outputs are registered or decoded from the state register only; no combinational input-to-output path.

Decomposition:
- Package mem_resp_pkg holds:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - default ADDR_W and DATA_W;
  - the LATENCY range limits.
- One sub-module, mem_array:
  - single-port, synchronous write, registered read;
  - ADDR_W/DATA_W parameters;
  - no reset on storage.
- FSM, counter and handshake registers stay in mem_responder.

Test Plan:
- Reset → RST low mid-cycle → req_ready=1, resp_valid=0, busy=0, resp_rdata=0 immediately, without waiting for CLK.
- Write/read, LATENCY=4:
  - Write 0xDEADBEEF to addr 0x3A accepted at edge 10 → resp_valid high after edge 14 only; req_ready high after edge 15.
  - Then a read of 0x3A → resp_rdata=0xDEADBEEF with resp_valid.
- Back-to-back, LATENCY=1:
  - req_valid held high with writes to 0x000, 0x001, 0x3FF (data 1, 2, 3) → one acceptance every 3 cycles.
  - Reads back 1, 2, 3; address 0x3FF wraps to no other location.
- Ignored stimulus:
  - Drive req_addr/req_wdata/req_write changes during WAIT → the original latched transaction completes unaffected.
  - A second request during WAIT is not accepted until IDLE.
- Abort:
  - Write 0x12345678 to 0x055 (prior contents 0xAAAA0000), RST asserted 2 cycles after acceptance → no resp_valid.
  - Later read of 0x055 returns 0xAAAA0000.
- LATENCY=15: the counter reaches the full range → resp_valid exactly 15 edges after acceptance; cnt returns to 0 with no underflow.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared constants for the cache-side backing memory responder: state encoding,
// default geometry and the legal access-latency range.
package mem_resp_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a cache controller (master) and the memory responder (slave).
interface mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port word memory: synchronous write, registered read. Storage is never reset;
// only the read-data register is, so the response data starts from zero.
module mem_array #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Holds the last read value between read accesses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Backing data memory for the cache refill/write-through path: accepts one request,
// waits LATENCY cycles, performs the access and pulses resp_valid for one cycle.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned LATENCY = 4
) (
    input  logic            CLK,
    input  logic            RST,
    mem_responder_if.slave  bus
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("mem_responder: LATENCY must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              access;
    logic              mem_we;
    logic              mem_re;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The single array access happens on the edge that leaves WAIT.
    assign access = (state_q == ST_WAIT) && (cnt_q == '0);
    assign mem_we = access && write_q;
    assign mem_re = access && !write_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk_i   (CLK),
        .rst_n_i (RST),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (bus.resp_rdata)
    );

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.busy       = (state_q == ST_WAIT) || (state_q == ST_RESP);

endmodule
